highpass_fir: RTL and testbench

//  Sequential (single-MAC) high-pass FIR on a 24-bit signed AXI-Stream sample path.

---
 rtl/highpass_fir_pkg.sv | 72 +++++++
 rtl/highpass_fir_mac.sv | 33 +++
 rtl/highpass_fir.sv | 106 ++++++++++
 tb/tb_highpass_fir.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/highpass_fir_pkg.sv
// highpass_fir_pkg
//   Shared constants, types and the coefficient ROM for the sequential
//   high-pass FIR.
//   - NTAPS/DW/CW/AW : taps per set, sample, coefficient and accumulator widths
//   - COEF           : four DC-null coefficient sets, indexed [sel][tap]
//   - round_to_sample: Q-format reduction of the accumulator to a DW-bit sample
//   Build option: HIGHPASS_FIR_SAT_EN clamps the reduced sample instead of
//   wrapping it.
package highpass_fir_pkg;

  localparam int unsigned NTAPS = 32;
  localparam int unsigned DW    = 24;
  localparam int unsigned CW    = 18;
  localparam int unsigned AW    = 47;
  localparam int unsigned PW    = $clog2(NTAPS);

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [AW-1:0] acc_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef logic [3:0][NTAPS-1:0][CW-1:0] coef_tab_t;

  // Set s is "x[n] minus the mean of the last span samples" with
  // span = NTAPS >> s, scaled so that h[0] stays just under +1.0. Tap 0 is
  // (span-1)*step and the next span-1 taps are -step, so each set sums to
  // exactly zero. Larger s gives a shorter window and a higher cutoff.
  function automatic coef_tab_t build_coef();
    coef_tab_t   t;
    int unsigned span;
    int unsigned step;
    t = '0;
    for (int unsigned s = 0; s < 4; s++) begin
      span = NTAPS >> s;
      if (span < 2) span = 2;
      step = (32'd1 << (CW - 1)) / span;
      for (int unsigned k = 0; k < NTAPS; k++) begin
        if (k == 0)
          t[s][k] = CW'((span - 1) * step);
        else if (k < span)
          t[s][k] = CW'(32'd0 - step);
      end
    end
    return t;
  endfunction

  localparam coef_tab_t COEF = build_coef();

  localparam acc_t RND_HALF = acc_t'(1) <<< (CW - 2);
  localparam acc_t Y_MAX    = (acc_t'(1) <<< (DW - 1)) - acc_t'(1);
  localparam acc_t Y_MIN    = -(acc_t'(1) <<< (DW - 1));

  // Q1.23 x Q1.17 products carry 40 fractional bits; drop 17 with
  // round-half-up to return to Q1.23.
  function automatic sample_t round_to_sample(input acc_t acc);
    acc_t y;
    y = (acc + RND_HALF) >>> (CW - 1);
`ifdef HIGHPASS_FIR_SAT_EN
    if (y > Y_MAX)
      y = Y_MAX;
    else if (y < Y_MIN)
      y = Y_MIN;
`endif
    return y[DW-1:0];
  endfunction

endpackage

// File: rtl/highpass_fir_mac.sv
// highpass_fir_mac
//   Signed multiply-accumulate used once per tap by highpass_fir.
//   clk/rstn : clock, asynchronous active-low reset
//   clr      : zero the accumulator (wins over en)
//   en       : add x*h into the accumulator
//   x, h     : signed sample and coefficient
//   acc      : running AW-bit signed sum
module highpass_fir_mac
  import highpass_fir_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  input  logic    clr,
  input  logic    en,
  input  sample_t x,
  input  coef_t   h,
  output acc_t    acc
);

  logic signed [DW+CW-1:0] prod;

  always_comb prod = x * h;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
  end

endmodule

// File: rtl/highpass_fir.sv
// highpass_fir
//   Sequential single-MAC high-pass FIR on a signed AXI-Stream sample path.
//   One sample is in flight at a time; s_axis_tuser picks one of four
//   coefficient sets per sample and is returned on m_axis_tuser.
//   s_axis_aclk / s_axis_arstn : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tready : input samples (signed DW bits)
//   s_axis_tuser               : coefficient-set select, captured with sample
//   m_axis_tdata/tvalid/tready : filtered samples (signed DW bits)
//   m_axis_tuser               : set select used for the output sample
//   Build option: HIGHPASS_FIR_SAT_EN saturates the output, otherwise it wraps.
module highpass_fir
  import highpass_fir_pkg::*;
(
  input  logic          s_axis_aclk,
  input  logic          s_axis_arstn,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [1:0]    s_axis_tuser,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [1:0]    m_axis_tuser
);

  state_t                 state;
  logic [NTAPS-1:0][DW-1:0] dline;
  logic [PW-1:0]          wr_ptr;
  logic [PW:0]            k;
  logic [1:0]             sel;
  logic                   s_fire;
  logic                   mac_clr;
  logic                   mac_en;
  logic [PW-1:0]          rd_ptr;
  sample_t                mac_x;
  coef_t                  mac_h;
  acc_t                   acc;

  assign s_axis_tready = (state == ST_IDLE) && !m_axis_tvalid;

  // wr_ptr keeps pointing at the newest sample for the whole MAC pass and
  // only advances once the result is taken, so tap k reads wr_ptr - k.
  // k runs one step past the last tap; that extra cycle lets the final
  // product land in acc before it is rounded.
  always_comb begin
    s_fire  = s_axis_tvalid && s_axis_tready;
    mac_clr = s_fire;
    mac_en  = (state == ST_MAC) && !k[PW];
    rd_ptr  = wr_ptr - k[PW-1:0];
    mac_x   = dline[rd_ptr];
    mac_h   = coef_t'(COEF[sel][k[PW-1:0]]);
  end

  highpass_fir_mac u_mac (
    .clk  (s_axis_aclk),
    .rstn (s_axis_arstn),
    .clr  (mac_clr),
    .en   (mac_en),
    .x    (mac_x),
    .h    (mac_h),
    .acc  (acc)
  );

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      state         <= ST_IDLE;
      dline         <= '0;
      wr_ptr        <= '0;
      k             <= '0;
      sel           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_fire) begin
            dline[wr_ptr] <= s_axis_tdata;
            sel           <= s_axis_tuser;
            k             <= '0;
            state         <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (k[PW]) begin
            m_axis_tdata  <= round_to_sample(acc);
            m_axis_tuser  <= sel;
            m_axis_tvalid <= 1'b1;
            wr_ptr        <= wr_ptr + PW'(1);
            state         <= ST_OUT;
          end else begin
            k <= k + (PW+1)'(1);
          end
        end
        ST_OUT: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_highpass_fir.sv
// tb_highpass_fir
//   Directed self-checking bench for highpass_fir: reset, impulse responses,
//   DC null, output stalls, per-set random data against a behavioural model,
//   overflow handling and reset during a MAC pass.
module tb_highpass_fir;

  localparam int NT = 32;

  // Per-set reference taps: tap 0, taps 1..SPAN-1, zero beyond.
  localparam int H0   [4] = '{126976, 122880, 114688, 98304};
  localparam int HT   [4] = '{-4096, -8192, -16384, -32768};
  localparam int SPAN [4] = '{32, 16, 8, 4};

  logic        clk;
  logic        s_arstn;
  logic [23:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [1:0]  s_tuser;
  logic [23:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [1:0]  m_tuser;

  int unsigned total;
  int unsigned bad;
  longint      hist [NT];

  highpass_fir dut (
    .s_axis_aclk   (clk),
    .s_axis_arstn  (s_arstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint tb_h(input logic [1:0] u, input int k);
    if (k == 0) return longint'(H0[u]);
    if (k < SPAN[u]) return longint'(HT[u]);
    return 0;
  endfunction

  function automatic logic [23:0] model_step(input logic [23:0] x, input logic [1:0] u);
    longint acc;
    longint y;
    for (int i = NT - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = longint'($signed(x));
    acc = 0;
    for (int k = 0; k < NT; k++) acc += hist[k] * tb_h(u, k);
    y = (acc + 65536) >>> 17;
`ifdef HIGHPASS_FIR_SAT_EN
    if (y > 8388607) y = 8388607;
    else if (y < -8388608) y = -8388608;
`endif
    return y[23:0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NT; k++) hist[k] = 0;
  endtask

  task automatic do_reset(input string tag);
    s_arstn = 1'b0;
    #100;
    check({tag, " rst m_tvalid"}, {31'b0, m_tvalid}, 32'd0);
    check({tag, " rst m_tdata"}, {8'b0, m_tdata}, 32'd0);
    check({tag, " rst m_tuser"}, {30'b0, m_tuser}, 32'd0);
    @(negedge clk);
    s_arstn = 1'b1;
    @(negedge clk);
    check({tag, " post-rst s_tready"}, {31'b0, s_tready}, 32'd1);
    check({tag, " post-rst m_tvalid"}, {31'b0, m_tvalid}, 32'd0);
    model_clear();
  endtask

  // One sample through the filter: handshake in, wait for the result, hold
  // m_tready low for 'stall' cycles, then take it.
  task automatic run(input logic [23:0] d, input logic [1:0] u, input int unsigned stall,
                     input bit hand, input logic [23:0] exp_hand, input string tag);
    logic [23:0] exp_y;
    int unsigned n;
    exp_y = model_step(d, u);
    if (hand) exp_y = exp_hand;
    @(negedge clk);
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " accept"}, {31'b0, s_tready}, 32'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tdata  = 24'($urandom);
    s_tuser  = 2'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tvalid && n < 200);
    check({tag, " latency"}, n, NT + 2);
    check({tag, " tdata"}, {8'b0, m_tdata}, {8'b0, exp_y});
    check({tag, " tuser"}, {30'b0, m_tuser}, {30'b0, u});
    check({tag, " s_tready busy"}, {31'b0, s_tready}, 32'd0);
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " stall tdata"}, {8'b0, m_tdata}, {8'b0, exp_y});
      check({tag, " stall tvalid"}, {31'b0, m_tvalid}, 32'd1);
    end
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    @(negedge clk);
    check({tag, " taken"}, {31'b0, m_tvalid}, 32'd0);
    check({tag, " ready again"}, {31'b0, s_tready}, 32'd1);
  endtask

  initial begin
    logic [23:0] e;
    total    = 0;
    bad      = 0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = '0;
    m_tready = 1'b0;
    model_clear();

    do_reset("init");

    // Impulse, set 3: 0.5 * h[k] -> h[k]*32.
    run(24'h400000, 2'd3, 2, 1'b1, 24'h300000, "imp3 n0");
    for (int n = 1; n < NT; n++) begin
      e = (n < 4) ? 24'hF00000 : 24'h000000;
      run(24'h000000, 2'd3, n % 3, 1'b1, e, $sformatf("imp3 n%0d", n));
    end

    // Impulse, set 0, then one sample past the window.
    run(24'h400000, 2'd0, 0, 1'b1, 24'h3E0000, "imp0 n0");
    for (int n = 1; n <= NT; n++) begin
      e = (n < NT) ? 24'hFE0000 : 24'h000000;
      run(24'h000000, 2'd0, n % 2, 1'b1, e, $sformatf("imp0 n%0d", n));
    end

    // DC input on set 0: ramps down during fill, exactly zero once full.
    for (int n = 0; n < 200; n++) begin
      e = (n < 31) ? 24'(32768 * (31 - n)) : 24'h000000;
      run(24'h100000, 2'd0, 0, 1'b1, e, $sformatf("dc n%0d", n));
    end

    // Random data on each set in turn, random stalls.
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 12; n++) begin
        run(24'($urandom), 2'(s), $urandom_range(0, 4), 1'b0, 24'h0,
            $sformatf("set%0d n%0d", s, n));
      end
    end

    // Overflow on set 3 (sum |h| = 1.5).
    run(24'h7FFFFF, 2'd3, 0, 1'b0, 24'h0, "ovf a0");
    run(24'h800000, 2'd3, 0, 1'b0, 24'h0, "ovf a1");
    run(24'h7FFFFF, 2'd3, 0, 1'b0, 24'h0, "ovf a2");
    run(24'h800000, 2'd3, 0, 1'b0, 24'h0, "ovf a3");
`ifdef HIGHPASS_FIR_SAT_EN
    run(24'h7FFFFF, 2'd3, 1, 1'b1, 24'h7FFFFF, "ovf a4");
`else
    run(24'h7FFFFF, 2'd3, 1, 1'b1, 24'h800000, "ovf a4");
`endif
    run(24'h800000, 2'd3, 0, 1'b1, 24'h800001, "ovf a5");
`ifdef HIGHPASS_FIR_SAT_EN
    run(24'h7FFFFF, 2'd3, 0, 1'b1, 24'h7FFFFF, "ovf a6");
`else
    run(24'h7FFFFF, 2'd3, 0, 1'b1, 24'h800000, "ovf a6");
`endif
    run(24'h7FFFFF, 2'd3, 0, 1'b1, 24'h400000, "ovf a7");
    run(24'h7FFFFF, 2'd3, 0, 1'b1, 24'h400000, "ovf a8");
`ifdef HIGHPASS_FIR_SAT_EN
    run(24'h800000, 2'd3, 2, 1'b1, 24'h800000, "ovf a9");
`else
    run(24'h800000, 2'd3, 2, 1'b1, 24'h400001, "ovf a9");
`endif

    // Reset part-way through a MAC pass: history and output must be gone.
    @(negedge clk);
    s_tdata  = 24'h3FFFFF;
    s_tuser  = 2'd1;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    repeat (10) @(negedge clk);
    check("midmac busy", {31'b0, s_tready}, 32'd0);
    do_reset("midmac");
    run(24'h400000, 2'd2, 1, 1'b1, 24'h380000, "midmac imp2 n0");
    run(24'h000000, 2'd2, 0, 1'b1, 24'hF80000, "midmac imp2 n1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
